// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: segment bit positions, blank pattern and
// the 16 value-to-pattern encodings (bits 6..0 = a..g).
package seg7_pkg;

  localparam int SEG_DP = 7;
  localparam int SEG_A  = 6;
  localparam int SEG_B  = 5;
  localparam int SEG_C  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 2;
  localparam int SEG_F  = 1;
  localparam int SEG_G  = 0;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_HA = 7'h77;
  localparam logic [6:0] SEG_HB = 7'h1F;
  localparam logic [6:0] SEG_HC = 7'h4E;
  localparam logic [6:0] SEG_HD = 7'h3D;
  localparam logic [6:0] SEG_HE = 7'h4F;
  localparam logic [6:0] SEG_HF = 7'h47;

  // Index by digit value: SEG_PAT[v] is the pattern for v.
  localparam logic [15:0][6:0] SEG_PAT = {
    SEG_HF, SEG_HE, SEG_HD, SEG_HC, SEG_HB, SEG_HA, SEG_9, SEG_8,
    SEG_7,  SEG_6,  SEG_5,  SEG_4,  SEG_3,  SEG_2,  SEG_1, SEG_0
  };

endpackage

// File: rtl/seg7_decode.sv
// 4-bit value to a..g pattern; values above 9 go dark unless hex decode is on.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_en,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_PAT[value];
    if (!hex_en && value > 4'd9) seg = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment scanner: prescaled digit slots with dead time,
// blank/blink/leading-zero masking, registered active-low enables and segments.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 1,
  parameter int DEAD_CYC     = 0,
  parameter int BLINK_FRAMES = 250,
  parameter int HEX_EN       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic [N_DIGITS-1:0]   blink,
  input  logic                  lz_en,
  output logic [N_DIGITS-1:0]   en,
  output logic [7:0]            disp
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CYC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  generate
    if (N_DIGITS < 1 || N_DIGITS > 16) begin : g_bad_ndig
      $error("seg7_scan_mux: N_DIGITS must be 1..16");
    end
    if (SCAN_DIV < 1) begin : g_bad_div
      $error("seg7_scan_mux: SCAN_DIV must be >= 1");
    end
    if (DEAD_CYC < 0 || DEAD_CYC > SCAN_DIV - 1) begin : g_bad_dead
      $error("seg7_scan_mux: DEAD_CYC must be 0..SCAN_DIV-1");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("seg7_scan_mux: BLINK_FRAMES must be >= 1");
    end
    if (HEX_EN != 0 && HEX_EN != 1) begin : g_bad_hex
      $error("seg7_scan_mux: HEX_EN must be 0 or 1");
    end
  endgenerate

  logic [CYC_W-1:0] cyc;
  logic [IDX_W-1:0] idx;
  logic [FRM_W-1:0] frm;
  logic             blink_ph;

  logic slot_end, last_idx, frm_end;
  assign slot_end = (cyc == CYC_W'(SCAN_DIV - 1));
  assign last_idx = (idx == IDX_W'(N_DIGITS - 1));
  assign frm_end  = (frm == FRM_W'(BLINK_FRAMES - 1));

  logic [N_DIGITS-1:0][3:0] val;
  assign val = digits;

  // tail[i]: every digit from i upward is a zero with no decimal point.
  logic [N_DIGITS-1:0] zero, tail;
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) zero[i] = (val[i] == 4'd0) && !dp[i];
    for (int i = 0; i < N_DIGITS; i++)
      tail[i] = ((zero >> i) == ({N_DIGITS{1'b1}} >> i));
  end

  logic dead;
  generate
    if (DEAD_CYC > 0) begin : g_dead
      assign dead = (cyc < CYC_W'(DEAD_CYC));
    end else begin : g_nodead
      assign dead = 1'b0;
    end
  endgenerate

  logic [6:0] seg;
  seg7_decode u_dec (
    .value  (val[idx]),
    .hex_en (HEX_EN != 0),
    .seg    (seg)
  );

  logic dark;
  assign dark = blank[idx]
              | (blink[idx] & blink_ph)
              | (lz_en & (idx != '0) & tail[idx]);

  logic [N_DIGITS-1:0] en_d;
  logic [7:0]          disp_d;
  always_comb begin
    en_d   = '1;
    disp_d = 8'h00;
    if (!dead) begin
      en_d[idx] = 1'b0;
      if (!dark) begin
        disp_d[6:0]    = seg;
        disp_d[SEG_DP] = dp[idx];
      end
    end
  end

  // Enables and segments share one register edge so neighbours never bleed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= '0;
      idx      <= '0;
      frm      <= '0;
      blink_ph <= 1'b0;
      en       <= '1;
      disp     <= 8'h00;
    end else begin
      en   <= en_d;
      disp <= disp_d;
      if (slot_end) begin
        cyc <= '0;
        if (last_idx) begin
          idx <= '0;
          if (frm_end) begin
            frm      <= '0;
            blink_ph <= ~blink_ph;
          end else begin
            frm <= frm + 1'b1;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cyc <= cyc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench: two scanner configurations share inputs; stimulus queues
// hand-derived per-cycle en/disp expectations, a negedge monitor pops and compares.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0, blank = '0, blink = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  en_a, en_b;
  logic [7:0]  disp_a, disp_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // A: one cycle per slot, hex decode, short blink period.
  seg7_scan_mux #(.N_DIGITS(4), .SCAN_DIV(1), .DEAD_CYC(0), .BLINK_FRAMES(2), .HEX_EN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blank(blank),
    .blink(blink), .lz_en(lz_en), .en(en_a), .disp(disp_a));

  // B: four cycles per slot with one dead cycle, decimal-only decode.
  seg7_scan_mux #(.N_DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .BLINK_FRAMES(2), .HEX_EN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blank(blank),
    .blink(blink), .lz_en(lz_en), .en(en_b), .disp(disp_b));

  typedef struct {
    logic [3:0] en;
    logic [7:0] disp;
    string      tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(string name, logic [3:0] en_g, logic [7:0] d_g,
                     logic [3:0] en_w, logic [7:0] d_w);
    checks++;
    if (en_g !== en_w || d_g !== d_w) begin
      errors++;
      $display("FAIL %s: got en=%b disp=%h, want en=%b disp=%h", name, en_g, d_g, en_w, d_w);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk(ea.tag, en_a, disp_a, ea.en, ea.disp);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk(eb.tag, en_b, disp_b, eb.en, eb.disp);
    end
  end

  // pat[i] is the expected disp for digit i; blmask digits go dark in frames 2,3,6,7...
  task automatic push_a(string tag, int frames, logic [3:0][7:0] pat, logic [3:0] blmask);
    exp_t e;
    e.tag = {tag, "_a_rst"}; e.en = 4'hF; e.disp = 8'h00; qa.push_back(e);
    for (int f = 0; f < frames; f++)
      for (int i = 0; i < 4; i++) begin
        e.tag  = $sformatf("%s_a_f%0d_d%0d", tag, f, i);
        e.en   = ~(4'b0001 << i);
        e.disp = (blmask[i] && ((f / 2) % 2 == 1)) ? 8'h00 : pat[i];
        qa.push_back(e);
      end
  endtask

  task automatic push_b(string tag, int frames, logic [3:0][7:0] pat);
    exp_t e;
    e.tag = {tag, "_b_rst"}; e.en = 4'hF; e.disp = 8'h00; qb.push_back(e);
    for (int f = 0; f < frames; f++)
      for (int i = 0; i < 4; i++) begin
        e.tag = $sformatf("%s_b_f%0d_d%0d_dead", tag, f, i);
        e.en = 4'hF; e.disp = 8'h00; qb.push_back(e);
        for (int c = 1; c < 4; c++) begin
          e.tag  = $sformatf("%s_b_f%0d_d%0d_c%0d", tag, f, i, c);
          e.en   = ~(4'b0001 << i);
          e.disp = pat[i];
          qb.push_back(e);
        end
      end
  endtask

  task automatic start();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (qa.size() > 0 || qb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d entries left, want 0", name, qa.size() + qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  initial begin
    // Plain scan of 1234 on both configurations.
    digits = 16'h1234;
    start();
    push_a("scan", 3, {8'h30, 8'h6D, 8'h79, 8'h33}, 4'b0000);
    push_b("scan", 2, {8'h30, 8'h6D, 8'h79, 8'h33});
    drain("scan");

    // Hex letters with a decimal point on digit 1; B blanks 10..15 but keeps dp.
    digits = 16'hABCF; dp = 4'b0010;
    start();
    push_a("hex", 1, {8'h77, 8'h1F, 8'hCE, 8'h47}, 4'b0000);
    push_b("hex", 1, {8'h00, 8'h00, 8'h80, 8'h00});
    drain("hex");

    // Leading-zero suppression.
    digits = 16'h0050; dp = 4'b0000; lz_en = 1'b1;
    start();
    push_a("lz50", 1, {8'h00, 8'h00, 8'h5B, 8'h7E}, 4'b0000);
    push_b("lz50", 1, {8'h00, 8'h00, 8'h5B, 8'h7E});
    drain("lz50");

    digits = 16'h0000;
    start();
    push_a("lz00", 1, {8'h00, 8'h00, 8'h00, 8'h7E}, 4'b0000);
    push_b("lz00", 1, {8'h00, 8'h00, 8'h00, 8'h7E});
    drain("lz00");

    // A decimal point on digit 2 keeps digits 2 and 1 from being suppressed.
    dp = 4'b0100;
    start();
    push_a("lzdp", 1, {8'h00, 8'hFE, 8'h7E, 8'h7E}, 4'b0000);
    push_b("lzdp", 1, {8'h00, 8'hFE, 8'h7E, 8'h7E});
    drain("lzdp");

    // Blink on digit 0 (dark in frames 2-3), blank on digit 3.
    dp = 4'b0000; lz_en = 1'b0; digits = 16'h1234;
    blink = 4'b0001; blank = 4'b1000;
    start();
    push_a("blink", 6, {8'h00, 8'h6D, 8'h79, 8'h33}, 4'b0001);
    drain("blink");

    // Async reset mid-slot at idx 2, then scan restarts at idx 0 with blink phase 0.
    blank = 4'b0000;
    start();
    repeat (11) @(posedge clk);
    #1;
    chk("mid_a_pre", en_a, disp_a, 4'b1011, 8'h6D);
    chk("mid_b_pre", en_b, disp_b, 4'b1011, 8'h6D);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_a_async", en_a, disp_a, 4'hF, 8'h00);
    chk("mid_b_async", en_b, disp_b, 4'hF, 8'h00);
    @(negedge clk);
    chk("mid_a_hold", en_a, disp_a, 4'hF, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    push_a("restart", 2, {8'h30, 8'h6D, 8'h79, 8'h33}, 4'b0001);
    push_b("restart", 1, {8'h30, 8'h6D, 8'h79, 8'h33});
    drain("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
